// File: rtl/mbox_mem_arb.sv
// mbox_mem_arb
//   Sequencer for the MBOX core-memory port. Three requesters (channel, CCA
//   writeback sweep, EBOX cache cycles) share one memory reference slot. For
//   each reference the block issues MEM START, waits for ACKN, counts the
//   returned read words and runs an NXM timeout. When a read times out, the
//   missing words are delivered as zero-fill. Sticky NXM and SBUS error flags
//   are held for the error-hold and diagnostic-read logic.
//
// Ports
//   clk             MBOX clock
//   RESET_L         asynchronous active-low reset
//   chan_rq/chan_wr channel request (level) and its write qualifier
//   cca_rq          CCA writeback request (always a write)
//   ebox_rq/ebox_wr EBOX cache-cycle request and its write qualifier
//   mem_ackn        memory ACKN pulse
//   mem_data_val    read data word valid from memory
//   mem_error       SBUS error reported by memory
//   nxm_err_clr     clears nxm_err
//   sbus_err_clr    clears sbus_err
//   grant           one-hot {chan,cca,ebox} owner of the current reference
//   mem_start       one-cycle MEM START pulse
//   mem_rd_rq       current reference is a read (while core_busy)
//   mem_wr_rq       current reference is a write (while core_busy)
//   core_busy       reference in progress
//   chan_core_busy  reference in progress that is owned by the channel
//   mem_busy        reference in progress or any request pending
//   word_cnt        words delivered so far in the current read
//   word_strobe     one pulse per delivered word (real or NXM fill)
//   nxm_data_val    the delivered word is NXM fill (force data to zero)
//   ref_done        one-cycle end-of-reference pulse
//   nxm_err         sticky non-existent-memory flag
//   sbus_err        sticky SBUS error flag
module mbox_mem_arb #(
  parameter int NXM_TIMEOUT   = 64,
  parameter int WORDS_PER_REF = 4
) (
  input  logic                             clk,
  input  logic                             RESET_L,
  input  logic                             chan_rq,
  input  logic                             chan_wr,
  input  logic                             cca_rq,
  input  logic                             ebox_rq,
  input  logic                             ebox_wr,
  input  logic                             mem_ackn,
  input  logic                             mem_data_val,
  input  logic                             mem_error,
  input  logic                             nxm_err_clr,
  input  logic                             sbus_err_clr,
  output logic [2:0]                       grant,
  output logic                             mem_start,
  output logic                             mem_rd_rq,
  output logic                             mem_wr_rq,
  output logic                             core_busy,
  output logic                             chan_core_busy,
  output logic                             mem_busy,
  output logic [$clog2(WORDS_PER_REF):0]   word_cnt,
  output logic                             word_strobe,
  output logic                             nxm_data_val,
  output logic                             ref_done,
  output logic                             nxm_err,
  output logic                             sbus_err
);

  localparam int CW = $clog2(WORDS_PER_REF) + 1;
  localparam int TW = $clog2(NXM_TIMEOUT);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] XFER     = 3'd3;
  localparam logic [2:0] NXM_FILL = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]    state_reg;
  logic [2:0]    grant_reg;
  logic          wr_reg;
  logic [TW-1:0] timer_reg;
  logic [CW-1:0] cnt_reg;
  logic          nxm_reg;
  logic          sbus_reg;

  logic any_rq;
  logic timeout;
  logic last_word;
  logic nxm_set;
  logic sbus_set;

  assign any_rq    = chan_rq | cca_rq | ebox_rq;
  assign timeout   = (timer_reg == TW'(NXM_TIMEOUT - 1));
  assign last_word = (cnt_reg == CW'(WORDS_PER_REF - 1));

  // A word or ACKN arriving on the timeout cycle takes precedence, so the
  // timeout only fires when the awaited event is absent.
  assign nxm_set  = timeout & (((state_reg == WAIT_ACK) & ~mem_ackn) |
                               ((state_reg == XFER) & ~mem_data_val));
  assign sbus_set = mem_error & ((state_reg == WAIT_ACK) | (state_reg == XFER));

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_reg <= IDLE;
      grant_reg <= 3'b000;
      wr_reg    <= 1'b0;
      timer_reg <= '0;
      cnt_reg   <= '0;
      nxm_reg   <= 1'b0;
      sbus_reg  <= 1'b0;
    end else begin
      // Set dominates a same-cycle clear.
      nxm_reg  <= nxm_set | (nxm_reg & ~nxm_err_clr);
      sbus_reg <= sbus_set | (sbus_reg & ~sbus_err_clr);
      case (state_reg)
        IDLE: begin
          if (any_rq) begin
            // Fixed priority CHAN > CCA > EBOX; CCA traffic is always a write.
            if (chan_rq) begin
              grant_reg <= 3'b100;
              wr_reg    <= chan_wr;
            end else if (cca_rq) begin
              grant_reg <= 3'b010;
              wr_reg    <= 1'b1;
            end else begin
              grant_reg <= 3'b001;
              wr_reg    <= ebox_wr;
            end
            state_reg <= START;
          end
        end
        START: begin
          timer_reg <= '0;
          state_reg <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ackn) begin
            timer_reg <= '0;
            state_reg <= wr_reg ? DONE : XFER;
          end else if (timeout) begin
            state_reg <= wr_reg ? DONE : NXM_FILL;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        XFER: begin
          if (mem_data_val) begin
            cnt_reg   <= cnt_reg + CW'(1);
            timer_reg <= '0;
            if (last_word) state_reg <= DONE;
          end else if (timeout) begin
            state_reg <= NXM_FILL;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        NXM_FILL: begin
          // One fill word per cycle until the reference has its full count.
          cnt_reg <= cnt_reg + CW'(1);
          if (last_word) state_reg <= DONE;
        end
        DONE: begin
          grant_reg <= 3'b000;
          wr_reg    <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core_busy      = (state_reg != IDLE);
  assign mem_start      = (state_reg == START);
  assign ref_done       = (state_reg == DONE);
  assign mem_rd_rq      = core_busy & ~wr_reg;
  assign mem_wr_rq      = core_busy & wr_reg;
  assign chan_core_busy = core_busy & grant_reg[2];
  // Requests are gated by reset so every output reads zero while held in reset.
  assign mem_busy       = core_busy | (RESET_L & any_rq);
  assign nxm_data_val   = (state_reg == NXM_FILL);
  assign word_strobe    = ((state_reg == XFER) & mem_data_val) | nxm_data_val;
  assign grant          = grant_reg;
  assign word_cnt       = cnt_reg;
  assign nxm_err        = nxm_reg;
  assign sbus_err       = sbus_reg;

endmodule

// File: tb/tb_mbox_mem_arb.sv
// Testbench for mbox_mem_arb: a driver plays requesters and memory from
// random or directed scripts, pushes the expected per-reference outcome into
// a scoreboard, and an independent monitor checks each completed reference.
module tb_mbox_mem_arb;

  localparam int NXM = 64;
  localparam int W   = 4;

  logic       clk;
  logic       RESET_L;
  logic       chan_rq, chan_wr, cca_rq, ebox_rq, ebox_wr;
  logic       mem_ackn, mem_data_val, mem_error, nxm_err_clr, sbus_err_clr;
  logic [2:0] grant;
  logic       mem_start, mem_rd_rq, mem_wr_rq, core_busy, chan_core_busy, mem_busy;
  logic [2:0] word_cnt;
  logic       word_strobe, nxm_data_val, ref_done, nxm_err, sbus_err;

  mbox_mem_arb #(.NXM_TIMEOUT(NXM), .WORDS_PER_REF(W)) dut (
    .clk(clk), .RESET_L(RESET_L),
    .chan_rq(chan_rq), .chan_wr(chan_wr), .cca_rq(cca_rq),
    .ebox_rq(ebox_rq), .ebox_wr(ebox_wr),
    .mem_ackn(mem_ackn), .mem_data_val(mem_data_val), .mem_error(mem_error),
    .nxm_err_clr(nxm_err_clr), .sbus_err_clr(sbus_err_clr),
    .grant(grant), .mem_start(mem_start), .mem_rd_rq(mem_rd_rq), .mem_wr_rq(mem_wr_rq),
    .core_busy(core_busy), .chan_core_busy(chan_core_busy), .mem_busy(mem_busy),
    .word_cnt(word_cnt), .word_strobe(word_strobe), .nxm_data_val(nxm_data_val),
    .ref_done(ref_done), .nxm_err(nxm_err), .sbus_err(sbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] grant;
    bit         wr;
    bit         first;
    int         start_cyc;
    int         lat;
    int         strobes;
    int         fills;
    bit         nxm;
    bit         sbus;
    int         wcnt;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic abort_run(input string name);
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    finish_run();
  endtask

  // Behavioural model: outcome of one reference from the memory script.
  // k = WAIT_ACK cycles before ACKN (>= NXM means never), g* = idle cycles
  // before each read word (>= NXM means memory goes silent).
  function automatic exp_t compute_exp(input logic [2:0] g, input bit wr, input bit first,
                                       input int start, input int k, input int g0,
                                       input int g1, input int g2, input int g3,
                                       input int err);
    exp_t e;
    int   gaps[4];
    int   wait_c, xfer, real_w, fill;
    bit   acked, to, stop;
    gaps   = '{g0, g1, g2, g3};
    acked  = (k <= NXM - 1);
    wait_c = acked ? k + 1 : NXM;
    xfer   = 0;
    real_w = 0;
    to     = 0;
    stop   = 0;
    if (!wr && acked) begin
      for (int i = 0; i < W; i++) begin
        if (!stop) begin
          if (gaps[i] <= NXM - 1) begin
            xfer += gaps[i] + 1;
            real_w++;
          end else begin
            xfer += NXM;
            to   = 1;
            stop = 1;
          end
        end
      end
    end
    fill        = wr ? 0 : W - real_w;
    e.grant     = g;
    e.wr        = wr;
    e.first     = first;
    e.start_cyc = start;
    e.lat       = 1 + wait_c + xfer + fill;
    e.strobes   = wr ? 0 : W;
    e.fills     = fill;
    e.nxm       = !acked || to;
    e.sbus      = (err == 1) || (err == 2 && !wr && acked && real_w >= 1);
    e.wcnt      = wr ? 0 : W;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit         in_ref = 0;
  bit         after_done = 0;
  int         st_cyc, o_str, o_fill, last_done = -10, exp_start;
  logic [2:0] o_grant;
  logic       o_wr, o_rd, o_flags;
  exp_t       me;

  initial begin
    forever begin
      @(negedge clk);
      if (!RESET_L) begin
        in_ref     = 0;
        after_done = 0;
      end else begin
        if (after_done) begin
          check("grant_after_done", grant, 0);
          check("word_cnt_after_done", word_cnt, 0);
          check("busy_after_done", core_busy, 0);
          after_done = 0;
        end
        if (mem_start) begin
          check("start_while_busy", in_ref, 0);
          in_ref  = 1;
          st_cyc  = cyc;
          o_grant = grant;
          o_wr    = mem_wr_rq;
          o_rd    = mem_rd_rq;
          o_flags = nxm_err | sbus_err;
          o_str   = 0;
          o_fill  = 0;
          check("mem_busy_at_start", mem_busy, 1);
        end
        if (word_strobe) o_str++;
        if (nxm_data_val) o_fill++;
        if (ref_done) begin
          check("ref_has_start", in_ref, 1);
          if (sbq.size() == 0) begin
            check("unexpected_ref_done", 1, 0);
          end else begin
            me = sbq.pop_front();
            exp_start = me.first ? me.start_cyc : last_done + 2;
            $display("ref grant=%b wr=%0d start=%0d lat=%0d words=%0d fill=%0d nxm=%0d sbus=%0d",
                     o_grant, o_wr, st_cyc, cyc - st_cyc, o_str, o_fill, nxm_err, sbus_err);
            check("grant", o_grant, me.grant);
            check("chan_core_busy", chan_core_busy, me.grant[2]);
            check("wr_at_start", o_wr, me.wr);
            check("rd_at_start", o_rd, !me.wr);
            check("wr_at_done", mem_wr_rq, me.wr);
            check("rd_at_done", mem_rd_rq, !me.wr);
            check("flags_at_start", o_flags, 0);
            check("start_cycle", st_cyc, exp_start);
            check("latency", cyc - st_cyc, me.lat);
            check("word_strobes", o_str, me.strobes);
            check("fill_words", o_fill, me.fills);
            check("word_cnt_done", word_cnt, me.wcnt);
            check("nxm_err", nxm_err, me.nxm);
            check("sbus_err", sbus_err, me.sbus);
          end
          in_ref     = 0;
          last_done  = cyc;
          after_done = 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ackn     = 1'b0;
    mem_data_val = 1'b0;
    mem_error    = 1'b0;
    nxm_err_clr  = 1'b0;
    sbus_err_clr = 1'b0;
    if (ref_done) done_seen = 1;
  endtask

  task automatic set_rq(input int b, input logic v);
    if (b == 2) chan_rq = v;
    else if (b == 1) cca_rq = v;
    else ebox_rq = v;
  endtask

  task automatic rand_script(output int k, output int g0, output int g1, output int g2,
                             output int g3, output int err, output bit clr);
    int r;
    int g[4];
    r = $urandom_range(0, 9);
    k = (r < 6) ? $urandom_range(0, 4) : (r == 6) ? NXM - 1 : (r == 7) ? NXM - 2 : NXM + 6;
    for (int i = 0; i < 4; i++) begin
      r    = $urandom_range(0, 19);
      g[i] = (r < 15) ? $urandom_range(0, 2) : (r == 15) ? NXM - 1 : (r == 16) ? NXM - 2 : NXM + 16;
    end
    g0  = g[0];
    g1  = g[1];
    g2  = g[2];
    g3  = g[3];
    err = $urandom_range(0, 2);
    clr = $urandom_range(0, 1);
  endtask

  // Plays memory for one reference whose request is already asserted.
  task automatic run_ref(input int owner, input bit wr, input int k, input int g0, input int g1,
                         input int g2, input int g3, input int err, input bit clr,
                         input bit flip, input bit drop);
    int n;
    int gaps[4];
    bit stop;
    gaps = '{g0, g1, g2, g3};
    n = 0;
    while (!mem_start && n < 8) begin
      tick();
      n++;
    end
    if (!mem_start) abort_run("mem_start_wait");
    done_seen = 0;
    if (flip && owner == 2) chan_wr = ~chan_wr;
    if (flip && owner == 0) ebox_wr = ~ebox_wr;
    if (drop) set_rq(owner, 1'b0);
    tick();
    if (err == 1) mem_error = 1'b1;
    if (k <= NXM - 1) begin
      repeat (k) begin
        if ($urandom_range(0, 3) == 0) mem_data_val = 1'b1;
        tick();
      end
      mem_ackn = 1'b1;
      tick();
      if (!wr) begin
        stop = 0;
        for (int i = 0; i < W; i++) begin
          if (!stop) begin
            if (gaps[i] > NXM - 1) begin
              stop = 1;
            end else begin
              repeat (gaps[i]) begin
                if ($urandom_range(0, 3) == 0) mem_ackn = 1'b1;
                tick();
              end
              mem_data_val = 1'b1;
              if (err == 2 && i == 0) mem_error = 1'b1;
              tick();
            end
          end
        end
      end
    end else begin
      repeat (NXM - 1) begin
        if ($urandom_range(0, 3) == 0) mem_data_val = 1'b1;
        tick();
      end
      if (clr) nxm_err_clr = 1'b1;
    end
    n = 0;
    while (!done_seen && n < 300) begin
      tick();
      n++;
    end
    if (!done_seen) abort_run("ref_done_wait");
    tick();
    set_rq(owner, 1'b0);
    nxm_err_clr  = 1'b1;
    sbus_err_clr = 1'b1;
  endtask

  task automatic scenario(input logic [2:0] mask, input bit cwr, input bit ewr, input bit given,
                          input int k, input int g0, input int g1, input int g2, input int g3,
                          input int err, input bit clr);
    int   rq_c;
    bit   first, wr, flip, drop;
    int   sk, s0, s1, s2, s3, serr;
    bit   sclr;
    logic [2:0] gv;
    exp_t e;
    tick();
    chan_wr      = cwr;
    ebox_wr      = ewr;
    chan_rq      = mask[2];
    cca_rq       = mask[1];
    ebox_rq      = mask[0];
    nxm_err_clr  = 1'b1;
    sbus_err_clr = 1'b1;
    rq_c  = cyc;
    first = 1;
    for (int b = 2; b >= 0; b--) begin
      if (mask[b]) begin
        wr = (b == 2) ? cwr : (b == 1) ? 1'b1 : ewr;
        if (given && first) begin
          sk = k; s0 = g0; s1 = g1; s2 = g2; s3 = g3; serr = err; sclr = clr;
        end else begin
          rand_script(sk, s0, s1, s2, s3, serr, sclr);
        end
        flip = ($urandom_range(0, 3) == 0);
        drop = ($urandom_range(0, 3) == 0);
        gv   = 3'b001 << b;
        e    = compute_exp(gv, wr, first, rq_c + 1, sk, s0, s1, s2, s3, serr);
        sbq.push_back(e);
        run_ref(b, wr, sk, s0, s1, s2, s3, serr, sclr, flip, drop);
        first = 0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_mem_start"}, mem_start, 0);
    check({tag, "_mem_rd_rq"}, mem_rd_rq, 0);
    check({tag, "_mem_wr_rq"}, mem_wr_rq, 0);
    check({tag, "_core_busy"}, core_busy, 0);
    check({tag, "_chan_core_busy"}, chan_core_busy, 0);
    check({tag, "_mem_busy"}, mem_busy, 0);
    check({tag, "_word_cnt"}, word_cnt, 0);
    check({tag, "_word_strobe"}, word_strobe, 0);
    check({tag, "_nxm_data_val"}, nxm_data_val, 0);
    check({tag, "_ref_done"}, ref_done, 0);
    check({tag, "_nxm_err"}, nxm_err, 0);
    check({tag, "_sbus_err"}, sbus_err, 0);
  endtask

  initial begin
    #900000;
    abort_run("watchdog");
  end

  initial begin
    int   n, rq_c;
    exp_t e;
    RESET_L = 1'b0;
    chan_rq = 0; chan_wr = 0; cca_rq = 0; ebox_rq = 0; ebox_wr = 0;
    mem_ackn = 0; mem_data_val = 0; mem_error = 0; nxm_err_clr = 0; sbus_err_clr = 0;
    done_seen = 0;
    #2;
    check_all_zero("reset");
    tick();
    RESET_L = 1'b1;
    tick();
    tick();

    // Directed cases.
    scenario(3'b001, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);              // EBOX read, ackn at +3
    scenario(3'b101, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);              // CHAN wins over EBOX
    scenario(3'b001, 0, 0, 1, NXM + 6, 0, 0, 0, 0, 0, 1);        // no ackn, clear on set cycle
    scenario(3'b001, 0, 0, 1, 2, 0, 1, NXM + 16, 0, 0, 0);       // 2 words then silence
    scenario(3'b100, 0, 0, 1, NXM - 1, 0, 0, 0, 0, 0, 0);        // ackn on timeout cycle
    scenario(3'b001, 0, 0, 1, 0, NXM - 1, 0, 0, 0, 2, 0);        // last-cycle word, error in XFER
    scenario(3'b010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);              // minimum write
    scenario(3'b100, 1, 0, 1, NXM + 6, 0, 0, 0, 0, 1, 0);        // write NXM plus SBUS error

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      scenario(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Reset in the middle of a read transfer.
    tick();
    ebox_wr = 1'b0;
    ebox_rq = 1'b1;
    n = 0;
    while (!mem_start && n < 8) begin
      tick();
      n++;
    end
    if (!mem_start) abort_run("reset_test_start");
    tick();
    mem_ackn  = 1'b1;
    mem_error = 1'b1;
    tick();
    mem_data_val = 1'b1;
    tick();
    check("pre_reset_busy", core_busy, 1);
    check("pre_reset_word_cnt", word_cnt, 1);
    check("pre_reset_sbus_err", sbus_err, 1);
    RESET_L = 1'b0;
    ebox_rq = 1'b0;
    cca_rq  = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    tick();
    RESET_L = 1'b1;
    rq_c = cyc;
    e = compute_exp(3'b010, 1'b1, 1'b1, rq_c + 1, 0, 0, 0, 0, 0, 0);
    sbq.push_back(e);
    run_ref(1, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    repeat (4) tick();
    check("scoreboard_drained", sbq.size(), 0);
    finish_run();
  end

endmodule
